mmio_master: RTL and testbench
==============================

# mmio_master

Single-outstanding MMIO bus initiator: accepts read/write commands over a valid/ready command port, drives the shared MMIO bus (`mmio_valid`/`mmio_write`/`mmio_addr`/`mmio_wdata`/`mmio_wstrb` out, `mmio_rdata`/`mmio_ready` in) that the peripherals (timer, UART, GPIO) answer, and returns read data or a timeout error over a valid/ready response port. It sits between a non-CPU bus owner, such as the debug UART bridge or test sequencer, and the peripheral MMIO fabric. A bounded wait protects against unmapped or hung responders.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles `mmio_valid` is held without `mmio_ready`. Range 0..65535. 0 disables the timeout.
- `ERR_RDATA`, default 32'h0000_0000: value returned in `rsp_rdata` on timeout.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `resetn` in 1: one clock; reset is asynchronous and active-low.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_write` in 1; `cmd_addr` in 32; `cmd_wdata` in 32; `cmd_wstrb` in 4: command payload.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_rdata` out 32: read data; 0 for writes.
- `rsp_err` out 1: 1 = timeout.
- `mmio_valid`, `mmio_write` out 1; `mmio_addr`, `mmio_wdata` out 32; `mmio_wstrb` out 4: bus request.
- `mmio_rdata` in 32, `mmio_ready` in 1: responder reply.
- `busy` out 1: state ≠ IDLE.
- `err_clr` in 1: clears `err_count`.
- `err_count` out 8: saturating timeout counter.

## Operation
- FSM states: IDLE, REQ, RSP, DRAIN.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`: latch the payload into the `mmio_*` registers and clear the wait counter. Go to REQ.
  - For reads, `mmio_wstrb` and `mmio_wdata` are driven 0.
- REQ:
  - `mmio_valid`=1; all `mmio_*` outputs are stable.
  - `mmio_ready`=1 sampled: drop `mmio_valid`, capture `rsp_rdata` (`mmio_rdata` for a read, 0 for a write), set `rsp_err`=0. Go to RSP.
  - Otherwise the wait counter increments. At `wait == TIMEOUT_CYCLES-1` with `mmio_ready`=0: drop `mmio_valid`, set `rsp_rdata`=`ERR_RDATA` and `rsp_err`=1, increment `err_count`. Go to DRAIN.
  - `mmio_ready` in the final allowed cycle counts as success; success wins over timeout.
- DRAIN: 2 cycles with `mmio_valid`=0 and `mmio_ready` ignored, which absorbs a late responder pulse. Then go to RSP.
- RSP: `rsp_valid`=1 with payload stable. On `rsp_ready`, go to IDLE.
- `mmio_ready` is ignored outside REQ.
- `err_count`:
  - Saturates at 255.
  - `err_clr` alone sets it to 0.
  - `err_clr` together with a timeout sets it to 1.
- Command fields other than those latched in IDLE are don't-care.

## Timing
- Reset values:
  - `cmd_ready`=0 during reset, then 1 in the first IDLE cycle.
  - All other outputs 0; state is IDLE.
- An asserted reset mid-REQ drops `mmio_valid` asynchronously. No response is produced.
- All outputs are registered.
- Latency, with edge 0 = command accept:
  - `mmio_valid` high in cycle 1.
  - With a one-wait-state responder (`mmio_ready` in cycle 2), `rsp_valid` is high in cycle 3.
- Handshake guarantees:
  - `mmio_valid` is high in the `mmio_ready` cycle and low in the following cycle.
  - Between transactions `mmio_valid` is low for at least 2 cycles (RSP, IDLE), so a responder's `ready <= valid && !ready` never double-fires.
- Timeout: `mmio_valid` is high for exactly `TIMEOUT_CYCLES` cycles. `rsp_valid` rises `TIMEOUT_CYCLES`+3 cycles after accept.
- Throughput: one transaction per at least 4 cycles.

## Structure
- Shared package `mmio_pkg`:
  - `MMIO_ADDR_W`=32, `MMIO_DATA_W`=32, `MMIO_STRB_W`=4.
  - FSM state enum `mmio_mst_state_t`.
  - `DRAIN_CYCLES`=2.
- No sub-module; wait counter, drain counter and `err_count` are inline (16-bit, 1-bit and 8-bit).

## Test plan
- Timer peripheral at base 0x80000020 as responder.
  - Write ARR (addr 0x8000002C, data 0x0000_1234, wstrb 0xF), then read addr 0x8000002C.
  - Required: `rsp_rdata`=0x0000_1234, `rsp_err`=0, `rsp_valid` 3 cycles after accept, `mmio_valid` high exactly 2 cycles.
- Partial write: PSC write with data 0xABCD, wstrb 0x1, then read PSC. Required: low byte 0xCD, high byte unchanged.
- Dead responder (`mmio_ready` tied 0), `TIMEOUT_CYCLES`=8, read.
  - Required: `mmio_valid` high 8 cycles, `rsp_err`=1, `rsp_rdata`=`ERR_RDATA`, `err_count`=1.
  - Stray `mmio_ready` pulse injected in DRAIN is ignored.
- Response backpressure: hold `rsp_ready`=0 for 5 cycles.
  - Required: `rsp_valid` and payload stable, `cmd_ready`=0, no `mmio_valid`.
  - Next command accepted the cycle after `rsp_ready`.
- `err_count` behaviour:
  - 256 timeouts give 255 (saturated).
  - `err_clr` together with a timeout gives 1.
- Assert `resetn` low mid-REQ.
  - Required: `mmio_valid`=0 immediately, `busy`=0, no `rsp_valid`.
  - After release, a new read completes normally.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bus initiator and its peripherals.
package mmio_pkg;

    localparam int MMIO_ADDR_W  = 32;
    localparam int MMIO_DATA_W  = 32;
    localparam int MMIO_STRB_W  = 4;

    // Idle bus cycles spent after a timeout so a late responder pulse is absorbed.
    localparam int DRAIN_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RSP,
        ST_DRAIN
    } mmio_mst_state_t;

    // One latched bus request, held stable for the whole REQ phase.
    typedef struct packed {
        logic                   write;
        logic [MMIO_ADDR_W-1:0] addr;
        logic [MMIO_DATA_W-1:0] wdata;
        logic [MMIO_STRB_W-1:0] wstrb;
    } mmio_req_t;

endpackage

// File: rtl/mmio_master.sv
// Single-outstanding MMIO bus initiator with bounded wait and timeout error reporting.
module mmio_master
    import mmio_pkg::*;
#(
    parameter int unsigned            TIMEOUT_CYCLES = 255,
    parameter logic [MMIO_DATA_W-1:0] ERR_RDATA      = '0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [MMIO_ADDR_W-1:0] cmd_addr,
    input  logic [MMIO_DATA_W-1:0] cmd_wdata,
    input  logic [MMIO_STRB_W-1:0] cmd_wstrb,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [MMIO_DATA_W-1:0] rsp_rdata,
    output logic                   rsp_err,
    output logic                   mmio_valid,
    output logic                   mmio_write,
    output logic [MMIO_ADDR_W-1:0] mmio_addr,
    output logic [MMIO_DATA_W-1:0] mmio_wdata,
    output logic [MMIO_STRB_W-1:0] mmio_wstrb,
    input  logic [MMIO_DATA_W-1:0] mmio_rdata,
    input  logic                   mmio_ready,
    output logic                   busy,
    input  logic                   err_clr,
    output logic [7:0]             err_count
);

    // A zero timeout means wait forever.
    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic        DRAIN_LAST   = 1'(DRAIN_CYCLES - 1);

    mmio_mst_state_t        state_q, state_d;
    mmio_req_t              req_q, req_d;
    logic                   mmio_valid_q, mmio_valid_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [MMIO_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_err_q, rsp_err_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   busy_q, busy_d;
    logic [15:0]            wait_q, wait_d;
    logic                   drain_q, drain_d;
    logic [7:0]             err_count_q, err_count_d;
    logic                   timeout;

    // Next-state and next-output decode; every output is registered from these values.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d      = state_q;
        req_d        = req_q;
        mmio_valid_d = mmio_valid_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        wait_d       = wait_q;
        drain_d      = drain_q;
        timeout      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    req_d.write  = cmd_write;
                    req_d.addr   = cmd_addr;
                    req_d.wdata  = cmd_write ? cmd_wdata : '0;
                    req_d.wstrb  = cmd_write ? cmd_wstrb : '0;
                    wait_d       = '0;
                    mmio_valid_d = 1'b1;
                    state_d      = ST_REQ;
                end
            end
            ST_REQ: begin
                // A ready in the last allowed cycle still counts as success.
                if (mmio_ready) begin
                    mmio_valid_d = 1'b0;
                    rsp_rdata_d  = req_q.write ? '0 : mmio_rdata;
                    rsp_err_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_RSP;
                end else if (TIMEOUT_EN && (wait_q == TIMEOUT_LAST)) begin
                    mmio_valid_d = 1'b0;
                    rsp_rdata_d  = ERR_RDATA;
                    rsp_err_d    = 1'b1;
                    drain_d      = 1'b0;
                    timeout      = 1'b1;
                    state_d      = ST_DRAIN;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);

        // Clear and timeout in the same cycle leaves exactly that one timeout counted.
        err_count_d = err_count_q;
        if (timeout) begin
            if (err_clr)
                err_count_d = 8'd1;
            else if (err_count_q != 8'hFF)
                err_count_d = err_count_q + 8'd1;
        end else if (err_clr) begin
            err_count_d = '0;
        end
    end

    // State and output registers; reset drops the bus request immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            mmio_valid_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            wait_q       <= '0;
            drain_q      <= 1'b0;
            err_count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together on the edge.
            state_q      <= state_d;
            req_q        <= req_d;
            mmio_valid_q <= mmio_valid_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
            wait_q       <= wait_d;
            drain_q      <= drain_d;
            err_count_q  <= err_count_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign mmio_valid = mmio_valid_q;
    assign mmio_write = req_q.write;
    assign mmio_addr  = req_q.addr;
    assign mmio_wdata = req_q.wdata;
    assign mmio_wstrb = req_q.wstrb;
    assign busy       = busy_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_mmio_master.sv
// Scoreboard bench for mmio_master with a timer-like responder at 0x80000020.
module tb_mmio_master;

    localparam logic [31:0] ERR_VAL  = 32'hBAD0_0BAD;
    localparam logic [31:0] A_PSC    = 32'h8000_0028;
    localparam logic [31:0] A_ARR    = 32'h8000_002C;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mmio_valid;
    logic        mmio_write;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic [3:0]  mmio_wstrb;
    logic [31:0] mmio_rdata;
    logic        mmio_ready;
    logic        busy;
    logic        err_clr = 1'b0;
    logic [7:0]  err_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    // Responder model: timer register file, one wait state, can be made dead.
    logic        alive = 1'b1;
    logic        stray_arm = 1'b0;
    logic        resp_ready_r = 1'b0;
    logic [31:0] resp_rdata_r = '0;
    logic [31:0] timer_regs [4] = '{default: 32'h0};
    logic        stray;

    always #10 clk = ~clk;

    mmio_master #(
        .TIMEOUT_CYCLES(8),
        .ERR_RDATA     (ERR_VAL)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mmio_valid(mmio_valid),
        .mmio_write(mmio_write),
        .mmio_addr (mmio_addr),
        .mmio_wdata(mmio_wdata),
        .mmio_wstrb(mmio_wstrb),
        .mmio_rdata(mmio_rdata),
        .mmio_ready(mmio_ready),
        .busy      (busy),
        .err_clr   (err_clr),
        .err_count (err_count)
    );

    // Stray ready only while the master drains (busy, no request, no response).
    assign stray      = stray_arm & busy & ~mmio_valid & ~rsp_valid;
    assign mmio_ready = resp_ready_r | stray;
    assign mmio_rdata = resp_rdata_r;

    always @(posedge clk) begin
        resp_ready_r <= alive && mmio_valid && !resp_ready_r;
        if (alive && mmio_valid && !resp_ready_r) begin
            resp_rdata_r <= mmio_write ? 32'h0 : timer_regs[mmio_addr[3:2]];
            if (mmio_write)
                for (int b = 0; b < 4; b++)
                    if (mmio_wstrb[b])
                        timer_regs[mmio_addr[3:2]][8*b +: 8] <= mmio_wdata[8*b +: 8];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (resetn && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                check("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
    end

    // Issue one command and wait (bounded) for rsp_valid; returns at that cycle's negedge.
    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_lat, input int exp_vlen,
                          input int clr_cyc);
        int  acc_wait = 0;
        int  lat = 0;
        int  vlen = 0;
        bit  got = 0;
        exp_t e;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb_q.push_back(e);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = strb;
        @(negedge clk);
        while (!cmd_ready && acc_wait < 10) begin
            acc_wait++;
            @(negedge clk);
        end
        check("accept_wait", 64'(acc_wait), 64'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_addr  = 32'hFFFF_FFFF;
        cmd_wdata = ~wdata;
        cmd_wstrb = 4'hF;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (clr_cyc > 0)
                err_clr = (cyc == clr_cyc);
            if (cyc == 1) begin
                check("mmio_addr", 64'(mmio_addr), 64'(addr));
                check("mmio_wdata", 64'(mmio_wdata), wr ? 64'(wdata) : 64'd0);
                check("mmio_wstrb", 64'(mmio_wstrb), wr ? 64'(strb) : 64'd0);
            end
            if (mmio_valid)
                vlen++;
            if (rsp_valid) begin
                lat = cyc;
                got = 1;
                break;
            end
        end
        err_clr = 1'b0;
        check("rsp_seen", 64'(got), 64'd1);
        check("rsp_latency", 64'(lat), 64'(exp_lat));
        check("mmio_valid_len", 64'(vlen), 64'(exp_vlen));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_mmio_valid", 64'(mmio_valid), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        check("rst_mmio_addr", 64'(mmio_addr), 64'd0);
        resetn = 1'b1;
        next_cycle();
        check("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

        // Timer ARR write then read back; one wait state.
        do_txn(1'b1, A_ARR, 32'h0000_1234, 4'hF, 32'h0, 1'b0, 3, 2, 0);
        next_cycle();
        do_txn(1'b0, A_ARR, 32'h0, 4'h0, 32'h0000_1234, 1'b0, 3, 2, 0);
        next_cycle();

        // PSC full write, byte-0 partial write, read back.
        do_txn(1'b1, A_PSC, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 3, 2, 0);
        next_cycle();
        do_txn(1'b1, A_PSC, 32'h0000_ABCD, 4'h1, 32'h0, 1'b0, 3, 2, 0);
        next_cycle();
        do_txn(1'b0, A_PSC, 32'h0, 4'h0, 32'h1234_56CD, 1'b0, 3, 2, 0);
        next_cycle();

        // Dead responder with a stray ready pulse during drain.
        alive = 1'b0;
        stray_arm = 1'b1;
        do_txn(1'b0, A_ARR, 32'h0, 4'h0, ERR_VAL, 1'b1, 11, 8, 0);
        next_cycle();
        check("err_count_one", 64'(err_count), 64'd1);
        check("idle_after_timeout", 64'(busy), 64'd0);

        // err_clr on its own.
        err_clr = 1'b1;
        next_cycle();
        err_clr = 1'b0;
        @(negedge clk);
        check("err_clr_alone", 64'(err_count), 64'd0);
        next_cycle();

        // Saturation after 256 timeouts.
        for (int i = 0; i < 256; i++) begin
            do_txn(1'b0, A_ARR, 32'h0, 4'h0, ERR_VAL, 1'b1, 11, 8, 0);
            next_cycle();
        end
        check("err_count_sat", 64'(err_count), 64'd255);

        // err_clr coinciding with the timeout edge (end of cycle 8).
        do_txn(1'b0, A_ARR, 32'h0, 4'h0, ERR_VAL, 1'b1, 11, 8, 8);
        next_cycle();
        check("err_clr_with_timeout", 64'(err_count), 64'd1);
        stray_arm = 1'b0;
        alive = 1'b1;

        // Response backpressure for 5 cycles.
        rsp_ready = 1'b0;
        do_txn(1'b0, A_ARR, 32'h0, 4'h0, 32'h0000_1234, 1'b0, 3, 2, 0);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check("bp_rsp_rdata", 64'(rsp_rdata), 64'h1234);
            check("bp_rsp_err", 64'(rsp_err), 64'd0);
            check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
            check("bp_mmio_valid", 64'(mmio_valid), 64'd0);
            if (i < 4)
                @(negedge clk);
        end
        next_cycle();
        rsp_ready = 1'b1;
        next_cycle();
        do_txn(1'b0, A_PSC, 32'h0, 4'h0, 32'h1234_56CD, 1'b0, 3, 2, 0);
        next_cycle();

        // Reset asserted mid-REQ against a dead responder.
        alive = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = A_ARR;
        next_cycle();
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_mmio_valid", 64'(mmio_valid), 64'd1);
        resetn = 1'b0;
        #1;
        check("async_rst_mmio_valid", 64'(mmio_valid), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        alive = 1'b1;
        repeat (4) next_cycle();
        check("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        do_txn(1'b0, A_ARR, 32'h0, 4'h0, 32'h0000_1234, 1'b0, 3, 2, 0);
        next_cycle();

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
